// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath: fetch/decode/execute/memory/writeback
// over one shared memory port, with a mem_ready handshake on every memory access.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Fun,
  input  logic       equal,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic       nPC_sel,
  output logic       ir_wr,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemWr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       ExtOp,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic [2:0] ALUctr,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_I   = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_BGTZ
  } cls_t;

  state_t     state_q, state_d;
  cls_t       cls_q, cls_dec;
  logic [2:0] alu_q, alu_dec;
  logic       taken;

  // Instruction class and R-type ALU op, valid while IR holds the current word
  always_comb begin
    cls_dec = C_NONE;
    alu_dec = 3'd0;
    case (Op)
      6'b000000: begin
        cls_dec = C_R;
        case (Fun)
          6'b100000: alu_dec = 3'd2;
          6'b100001: alu_dec = 3'd4;
          6'b100010: alu_dec = 3'd6;
          6'b100011: alu_dec = 3'd6;
          6'b100100: alu_dec = 3'd0;
          6'b100101: alu_dec = 3'd1;
          6'b000000: alu_dec = 3'd5;
          6'b101010: alu_dec = 3'd3;
          6'b101011: alu_dec = 3'd7;
          default:   cls_dec = C_NONE;
        endcase
      end
      6'b001000: cls_dec = C_ADDI;
      6'b100011: cls_dec = C_LW;
      6'b101011: cls_dec = C_SW;
      6'b000100: cls_dec = C_BEQ;
      6'b000101: cls_dec = C_BNE;
      6'b000111: cls_dec = C_BGTZ;
      default:   cls_dec = C_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      alu_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= cls_dec;
        alu_q <= alu_dec;
      end
    end
  end

  assign taken = ((cls_q == C_BEQ)  &  equal) |
                 ((cls_q == C_BNE)  & ~equal) |
                 ((cls_q == C_BGTZ) & ~equal & ~sign);

  always_comb begin
    state_d    = state_q;
    pc_wr      = 1'b0;
    nPC_sel    = 1'b0;
    ir_wr      = 1'b0;
    IorD       = 1'b0;
    MemRd      = 1'b0;
    MemWr      = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    ExtOp      = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    ALUctr     = 3'd0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRd = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls_dec)
          C_R:                  state_d = S_EXEC_R;
          C_ADDI:               state_d = S_EXEC_I;
          C_LW, C_SW:           state_d = S_ADDR;
          C_BEQ, C_BNE, C_BGTZ: state_d = S_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_R, S_WB_R: begin
        RegDst = 1'b1;
        ALUctr = alu_q;
        if (state_q == S_WB_R) begin
          RegWr      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d    = S_WB_R;
        end
      end
      S_EXEC_I, S_WB_I: begin
        ALUSrc = 1'b1;
        ExtOp  = 1'b1;
        ALUctr = 3'd2;
        if (state_q == S_WB_I) begin
          RegWr      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d    = S_WB_I;
        end
      end
      S_ADDR: begin
        ALUSrc  = 1'b1;
        ExtOp   = 1'b1;
        ALUctr  = 3'd2;
        state_d = (cls_q == C_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRd  = 1'b1;
        IorD   = 1'b1;
        ALUSrc = 1'b1;
        ExtOp  = 1'b1;
        ALUctr = 3'd2;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        MemtoReg   = 1'b1;
        RegWr      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        MemWr  = 1'b1;
        IorD   = 1'b1;
        ALUSrc = 1'b1;
        ExtOp  = 1'b1;
        ALUctr = 3'd2;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_BRANCH: begin
        ALUctr     = 3'd6;
        pc_wr      = taken;
        nPC_sel    = taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // An instruction caught by reset must leave no architectural side effect
    if (reset) begin
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      MemRd      = 1'b0;
      MemWr      = 1'b0;
      RegWr      = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: every cycle's expected control word is queued
// with its stimulus and compared at the following falling edge.
module tb_multicycle_ctrl;

  logic       clk, reset;
  logic [5:0] Op, Fun;
  logic       equal, sign, mem_ready;
  logic       pc_wr, nPC_sel, ir_wr, IorD, MemRd, MemWr, RegWr, RegDst, ExtOp, ALUSrc, MemtoReg;
  logic [2:0] ALUctr;
  logic       illegal, instr_done;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Fun(Fun), .equal(equal), .sign(sign),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .nPC_sel(nPC_sel), .ir_wr(ir_wr), .IorD(IorD),
    .MemRd(MemRd), .MemWr(MemWr), .RegWr(RegWr), .RegDst(RegDst), .ExtOp(ExtOp),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ALUctr(ALUctr), .illegal(illegal),
    .instr_done(instr_done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: pc_wr nPC_sel ir_wr IorD MemRd MemWr RegWr RegDst ExtOp ALUSrc MemtoReg
  typedef struct packed {
    logic [3:0]  st;
    logic [10:0] flags;
    logic [2:0]  alu;
    logic        ill;
    logic        done;
  } ctl_t;

  localparam logic [10:0] F_NONE   = 11'b00000000000;
  localparam logic [10:0] F_FETCH  = 11'b10101000000;
  localparam logic [10:0] F_FWAIT  = 11'b00001000000;
  localparam logic [10:0] F_EXR    = 11'b00000001000;
  localparam logic [10:0] F_WBR    = 11'b00000011000;
  localparam logic [10:0] F_EXI    = 11'b00000000110;
  localparam logic [10:0] F_WBI    = 11'b00000010110;
  localparam logic [10:0] F_MEMRD  = 11'b00011000110;
  localparam logic [10:0] F_WBMEM  = 11'b00000010001;
  localparam logic [10:0] F_MEMWR  = 11'b00010100110;
  localparam logic [10:0] F_WRRST  = 11'b00010000110;
  localparam logic [10:0] F_TAKEN  = 11'b11000000000;

  ctl_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic ctl_t mk(input logic [3:0] st, input logic [10:0] f,
                              input logic [2:0] alu, input logic ill, input logic done);
    mk = {st, f, alu, ill, done};
  endfunction

  task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle's handshake inputs, queue its expectation, check at negedge
  task automatic cyc(input string tag, input logic mr, input logic eq, input logic sg,
                     input ctl_t exp);
    ctl_t e, obs;
    mem_ready = mr;
    equal     = eq;
    sign      = sg;
    exp_q.push_back(exp);
    @(negedge clk);
    obs = {state, pc_wr, nPC_sel, ir_wr, IorD, MemRd, MemWr, RegWr, RegDst, ExtOp, ALUSrc,
           MemtoReg, ALUctr, illegal, instr_done};
    e = exp_q.pop_front();
    check_val(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
    Op  = op;
    Fun = fn;
    cyc({tag, "_fetch"}, 1'b1, 1'b0, 1'b0, mk(4'd0, F_FETCH, 3'd0, 1'b0, 1'b0));
    cyc({tag, "_decode"}, 1'b1, 1'b0, 1'b0, mk(4'd1, F_NONE, 3'd0, 1'b0, 1'b0));
  endtask

  task automatic run_r(input string tag, input logic [5:0] fn, input logic [2:0] alu);
    fetch_decode(tag, 6'b000000, fn);
    cyc({tag, "_exec"}, 1'b1, 1'b0, 1'b0, mk(4'd2, F_EXR, alu, 1'b0, 1'b0));
    cyc({tag, "_wb"},   1'b1, 1'b0, 1'b0, mk(4'd7, F_WBR, alu, 1'b0, 1'b1));
  endtask

  task automatic run_br(input string tag, input logic [5:0] op, input logic eq, input logic sg,
                        input logic tk);
    fetch_decode(tag, op, 6'b000000);
    cyc({tag, "_branch"}, 1'b1, eq, sg,
        mk(4'd10, tk ? F_TAKEN : F_NONE, 3'd6, 1'b0, 1'b1));
  endtask

  initial begin
    reset = 1'b1; Op = 6'd0; Fun = 6'd0; equal = 1'b0; sign = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", 1'b1, 1'b0, 1'b0, mk(4'd0, F_NONE, 3'd0, 1'b0, 1'b0));
    reset = 1'b0;

    run_r("add",  6'b100000, 3'd2);
    run_r("sub",  6'b100010, 3'd6);
    run_r("sll",  6'b000000, 3'd5);
    run_r("sltu", 6'b101011, 3'd7);

    // addi with one fetch wait state
    Op = 6'b001000;
    cyc("addi_fwait", 1'b0, 1'b0, 1'b0, mk(4'd0, F_FWAIT, 3'd0, 1'b0, 1'b0));
    fetch_decode("addi", 6'b001000, 6'b000000);
    cyc("addi_exec", 1'b1, 1'b0, 1'b0, mk(4'd3, F_EXI, 3'd2, 1'b0, 1'b0));
    cyc("addi_wb",   1'b1, 1'b0, 1'b0, mk(4'd8, F_WBI, 3'd2, 1'b0, 1'b1));

    // lw with three wait states in MEM_RD: 8 cycles total
    fetch_decode("lw", 6'b100011, 6'b000000);
    cyc("lw_addr", 1'b1, 1'b0, 1'b0, mk(4'd4, F_EXI, 3'd2, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc("lw_memrd_wait", 1'b0, 1'b0, 1'b0, mk(4'd5, F_MEMRD, 3'd2, 1'b0, 1'b0));
    cyc("lw_memrd", 1'b1, 1'b0, 1'b0, mk(4'd5, F_MEMRD, 3'd2, 1'b0, 1'b0));
    cyc("lw_wb",    1'b1, 1'b0, 1'b0, mk(4'd9, F_WBMEM, 3'd0, 1'b0, 1'b1));

    run_br("beq_eq1",   6'b000100, 1'b1, 1'b0, 1'b1);
    run_br("beq_eq0",   6'b000100, 1'b0, 1'b0, 1'b0);
    run_br("bne_eq0",   6'b000101, 1'b0, 1'b0, 1'b1);
    run_br("bne_eq1",   6'b000101, 1'b1, 1'b0, 1'b0);
    run_br("bgtz_00",   6'b000111, 1'b0, 1'b0, 1'b1);
    run_br("bgtz_10",   6'b000111, 1'b1, 1'b0, 1'b0);
    run_br("bgtz_01",   6'b000111, 1'b0, 1'b1, 1'b0);

    // Undecodable opcode, then undecodable R-type funct
    Op = 6'b111111; Fun = 6'b000000;
    cyc("ill_op_fetch",  1'b1, 1'b0, 1'b0, mk(4'd0, F_FETCH, 3'd0, 1'b0, 1'b0));
    cyc("ill_op_decode", 1'b1, 1'b0, 1'b0, mk(4'd1, F_NONE, 3'd0, 1'b1, 1'b0));
    Op = 6'b000000; Fun = 6'b000001;
    cyc("ill_fn_fetch",  1'b1, 1'b0, 1'b0, mk(4'd0, F_FETCH, 3'd0, 1'b0, 1'b0));
    cyc("ill_fn_decode", 1'b1, 1'b0, 1'b0, mk(4'd1, F_NONE, 3'd0, 1'b1, 1'b0));

    // sw stalled in MEM_WR, then abandoned by reset
    fetch_decode("sw", 6'b101011, 6'b000000);
    cyc("sw_addr", 1'b1, 1'b0, 1'b0, mk(4'd4, F_EXI, 3'd2, 1'b0, 1'b0));
    cyc("sw_memwr_wait", 1'b0, 1'b0, 1'b0, mk(4'd6, F_MEMWR, 3'd2, 1'b0, 1'b0));
    cyc("sw_memwr_wait", 1'b0, 1'b0, 1'b0, mk(4'd6, F_MEMWR, 3'd2, 1'b0, 1'b0));
    reset = 1'b1;
    cyc("sw_reset", 1'b0, 1'b0, 1'b0, mk(4'd6, F_WRRST, 3'd2, 1'b0, 1'b0));
    reset = 1'b0;

    // Normal sw after the abandoned one
    fetch_decode("sw2", 6'b101011, 6'b000000);
    cyc("sw2_addr",  1'b1, 1'b0, 1'b0, mk(4'd4, F_EXI, 3'd2, 1'b0, 1'b0));
    cyc("sw2_memwr", 1'b1, 1'b0, 1'b0, mk(4'd6, F_MEMWR, 3'd2, 1'b0, 1'b1));
    run_r("and", 6'b100100, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the MIPS-subset datapath: it splits each instruction into fetch, decode, execute, memory and writeback states over a single shared memory port. It drives the same datapath control signals as the single-cycle decoder, plus PC/IR write enables and memory strobes. It sits between the instruction register and the register file, ALU, extender and memory muxes, and adds a ready handshake to memory.

## Interface
Parameters:
- none; the opcode, funct and ALUctr encodings are fixed below.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- Op  in  6  IR[31:26]; stable from the cycle after ir_wr until the next ir_wr
- Fun  in  6  IR[5:0]
- equal  in  1  ALU zero flag
- sign  in  1  ALU result bit 31
- mem_ready  in  1  memory completes current MemRd/MemWr this cycle
- pc_wr  out  1  PC load enable
- nPC_sel  out  1  0 = PC+4, 1 = branch target
- ir_wr  out  1  IR load enable
- IorD  out  1  memory address: 0 = PC, 1 = ALUout
- MemRd, MemWr  out  1 each  memory strobes
- RegWr, RegDst, ExtOp, ALUSrc, MemtoReg  out  1 each  same meaning as the single-cycle control
- ALUctr  out  3  0 and, 1 or, 2 add, 3 slt, 4 addu, 5 sll, 6 sub, 7 sltu
- illegal  out  1  one-cycle pulse: undecodable instruction
- instr_done  out  1  one-cycle pulse: instruction retired
- state  out  4  current state encoding, for debug

## Operation
- Supported instructions:
  - R-type (Op 000000): add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, sll 000000, slt 101010, sltu 101011.
  - I-type by Op: addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, bgtz 000111.
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BRANCH=10. Codes 11–15 are unreachable and go to FETCH.
- FETCH:
  - Outputs: MemRd=1, IorD=0.
  - If mem_ready: ir_wr=1, pc_wr=1, nPC_sel=0, next DECODE. Otherwise stay.
- DECODE: one cycle; latch the instruction class internally, then branch by class:
  - R-type → EXEC_R
  - addi → EXEC_I
  - lw/sw → ADDR
  - beq/bne/bgtz → BRANCH
  - anything else (including unknown funct): illegal=1, instr_done=0, next FETCH.
- EXEC_R → WB_R:
  - Both states: RegDst=1, ALUSrc=0, ALUctr per funct.
  - WB_R adds RegWr=1 and instr_done=1, then next FETCH.
- EXEC_I → WB_I:
  - Both states: RegDst=0, ALUSrc=1, ExtOp=1, ALUctr=2.
  - WB_I adds RegWr=1 and instr_done=1, then next FETCH.
- ADDR: ALUSrc=1, ExtOp=1, ALUctr=2; next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRd=1, IorD=1, ALU controls held; stay until mem_ready, then next WB_MEM.
- WB_MEM: MemtoReg=1, RegDst=0, RegWr=1, instr_done=1; next FETCH.
- MEM_WR: MemWr=1, IorD=1, ALU controls held; stay until mem_ready. On mem_ready: instr_done=1, next FETCH.
- BRANCH: ALUSrc=0, ALUctr=6 (sub).
  - taken = (beq & equal) | (bne & ~equal) | (bgtz & ~equal & ~sign).
  - pc_wr = nPC_sel = taken; instr_done=1; next FETCH.
- Any signal not listed for a state is 0 in that state, including ALUctr=0.

## Timing
- Outputs are Moore (decoded from state plus latched class), except:
  - pc_wr, ir_wr, instr_done in FETCH/MEM_WR, which also depend on mem_ready;
  - pc_wr, nPC_sel in BRANCH, which also depend on equal/sign.
- Reset:
  - In any cycle where reset=1, pc_wr, ir_wr, MemRd, MemWr, RegWr, illegal and instr_done are forced to 0.
  - The next edge sets state=FETCH. All other outputs then take their FETCH values.
- Reset mid-operation: the instruction is abandoned with no partial writeback.
  - MemWr drops in the same cycle reset is sampled high.
  - The latched class is cleared.
- Latency with mem_ready always 1:
  - R-type and addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - illegal: 2 cycles
  - Each wait cycle (mem_ready=0) in FETCH, MEM_RD or MEM_WR adds 1 cycle.
- Handshake: the memory request is held constant until mem_ready. There is no timeout.
- Writes are never combined: at most one of RegWr, MemWr, pc_wr-taken is active per cycle, except FETCH's pc_wr together with ir_wr.

## Test plan
- Reset then add (Op 000000, Fun 100000), mem_ready=1:
  - Required state sequence: 0,1,2,7,0.
  - RegWr=1 and RegDst=1 only in WB_R, with ALUctr=2 there.
  - instr_done pulses once.
- lw with mem_ready low for 3 cycles in MEM_RD:
  - MemRd and IorD=1 are held for 4 cycles.
  - WB_MEM then has MemtoReg=1 and RegWr=1.
  - Total 8 cycles.
- beq with equal=1: pc_wr=nPC_sel=1 in BRANCH. Repeat with equal=0: pc_wr=0. In both cases instr_done=1 and no RegWr/MemWr.
- bgtz with (equal,sign) = (0,0), (1,0), (0,1): taken only for (0,0).
- Op 111111: illegal pulses in DECODE, then FETCH with no writes. Repeat with R-type Fun 000001: same response.
- sw stalled in MEM_WR, then reset=1:
  - MemWr=0 in the reset cycle; state=0 afterwards.
  - No instr_done.
  - The next fetch proceeds normally.
